timer_tick_gen: RTL and testbench
=================================

// Module: timer_tick_gen
// PURPOSE
//  Prescaler / count-enable generator feeding the APB timer counter (TCNT).
//  Divides pclk by a TCR-selected ratio and emits a one-cycle tick; counter
//  steps (up or down) only on tick. Handles start/stop/restart of the count
//  and TCNT reloads so the counter never sees a short or glitched period.
// PARAMETERS
//  CKS_W  2  width of clock-select field; N = 2^(cks+1) -> 2,4,8,16
//  DIV_W  4  prescaler width; must equal 2^CKS_W (holds N-1 = 15)
// PORTS
//  pclk        in   1      APB clock; only clock in the block
//  preset      in   1      synchronous, active-high reset
//  en          in   1      count enable (TCR enable bit)
//  cks         in   CKS_W  clock select (TCR); 00=/2 01=/4 10=/8 11=/16
//  load        in   1      one-cycle pulse: TCNT written/reloaded
//  tick        out  1      registered one-cycle count-enable pulse to TCNT
//  busy        out  1      1 while in RUN
//  cks_active  out  CKS_W  divide select currently applied
// BEHAVIOUR
//  Reset: clock and reset are fixed: single clock pclk; preset synchronous,
//   active-high. On any edge with preset=1: state=IDLE, div_cnt=0, tick=0,
//   busy=0, cks_active=0. preset overrides all other inputs.
//  FSM states IDLE, RUN. busy = (state==RUN), registered.
//  IDLE: div_cnt held 0, tick=0; load ignored. Edge E0 sampling en=1 ->
//   RUN, div_cnt<=0, cks_active<=cks.
//  RUN, per edge, priority order:
//   1) en=0   -> IDLE, div_cnt<=0, tick<=0 (partial prescale discarded;
//      a tick due this edge is suppressed)
//   2) load=1 -> div_cnt<=0, tick<=0, stay RUN (phase restarts)
//   3) div_cnt==N-1 (N from cks_active) -> div_cnt<=0, tick<=1,
//      cks_active<=cks (new select applied only at tick boundary)
//   4) else   -> div_cnt<=div_cnt+1, tick<=0
//  Latency: tick high for exactly one cycle after edges E0+N, E0+2N, ...;
//   after restart from IDLE the first tick is again N edges later.
//  cks change mid-period: current period completes at old N; next period
//   uses new N. No period shorter than min(old N, new N) ever produced.
//  load coincident with terminal count: load wins, no tick.
//  en toggling 1->0->1 on consecutive edges: full restart, first tick at
//   re-enable edge + N.
//  div_cnt compare uses DIV_W-bit unsigned; never exceeds N-1, no wrap.
//  tick never asserted on two consecutive cycles (N>=2).
// TESTING
//  1 preset=1 for 3 cycles with en=1,cks=11 -> tick=0,busy=0,cks_active=00
//    throughout; first tick 16 edges after preset release.
//  2 en=1,cks=00 for 100 cycles -> exactly 50 ticks, spaced 2 cycles,
//    first at E0+2.
//  3 cks=11: en=1 200 cyc -> 12 ticks; en=0 200 cyc -> 0 ticks, busy=0;
//    en=1 again -> first tick exactly 16 cycles after re-enable edge.
//  4 cks=00 running, switch cks=11 between ticks -> one more /2 tick, then
//    ticks every 16; cks_active changes in the cycle tick first rises.
//  5 cks=11, load pulse when div_cnt=9 -> no tick 6 cycles later; next tick
//    16 cycles after load edge; load while IDLE -> no effect.
//  6 cks=01, drop en on the edge a tick is due -> tick stays 0, state IDLE,
//    div_cnt=0.

Source files
------------

// File: rtl/timer_tick_gen_if.sv
// ============================================================================
// Module   : timer_tick_gen_if
// Brief    : Control/status bundle between TCR logic and the tick generator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface timer_tick_gen_if #(
    parameter int CKS_W = 2
);
    logic             en;
    logic [CKS_W-1:0] cks;
    logic             load;
    logic             tick;
    logic             busy;
    logic [CKS_W-1:0] cks_active;

    modport master (
        output en, cks, load,
        input  tick, busy, cks_active
    );

    modport slave (
        input  en, cks, load,
        output tick, busy, cks_active
    );
endinterface

`default_nettype wire

// File: rtl/timer_tick_gen.sv
// ============================================================================
// Module   : timer_tick_gen
// Brief    : Prescaler producing a one-cycle count-enable tick every N pclk.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_tick_gen #(
    parameter int CKS_W = 2,
    parameter int DIV_W = 4
) (
    input  wire               pclk,
    input  wire               preset,
    timer_tick_gen_if.slave   bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DIV_W-1:0] r_div_cnt;
    logic [DIV_W-1:0] w_div_nxt;
    logic             r_tick;
    logic             w_tick_nxt;
    logic [CKS_W-1:0] r_cks_act;
    logic [CKS_W-1:0] w_cks_nxt;
    logic [DIV_W-1:0] w_div_max;

    // Terminal count N-1 where N = 2^(cks_active+1)
    assign w_div_max = DIV_W'((32'd2 << r_cks_act) - 32'd1);

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state   <= ST_IDLE;
            r_div_cnt <= '0;
            r_tick    <= 1'b0;
            r_cks_act <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_div_cnt <= w_div_nxt;
            r_tick    <= w_tick_nxt;
            r_cks_act <= w_cks_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div_cnt;
        w_tick_nxt  = 1'b0;
        w_cks_nxt   = r_cks_act;
        case (r_state)
            ST_IDLE: begin
                w_div_nxt = '0;
                if (bus.en) begin
                    w_state_nxt = ST_RUN;
                    w_cks_nxt   = bus.cks;
                end
            end
            ST_RUN: begin
                if (!bus.en) begin
                    w_state_nxt = ST_IDLE;
                    w_div_nxt   = '0;
                end else if (bus.load) begin
                    w_div_nxt = '0;
                end else if (r_div_cnt == w_div_max) begin
                    // New select only takes effect on a period boundary
                    w_div_nxt  = '0;
                    w_tick_nxt = 1'b1;
                    w_cks_nxt  = bus.cks;
                end else begin
                    w_div_nxt = r_div_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_div_nxt   = '0;
            end
        endcase
    end

    assign bus.tick       = r_tick;
    assign bus.busy       = (r_state == ST_RUN);
    assign bus.cks_active = r_cks_act;

endmodule

`default_nettype wire

// File: tb/tb_timer_tick_gen.sv
// ============================================================================
// Module   : tb_timer_tick_gen
// Brief    : Directed bench with a period-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_timer_tick_gen;

    logic pclk   = 1'b0;
    logic preset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    bit   check_on = 1'b0;

    timer_tick_gen_if #(.CKS_W(2)) bus ();

    timer_tick_gen #(.CKS_W(2), .DIV_W(4)) dut (
        .pclk   (pclk),
        .preset (preset),
        .bus    (bus)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a period starts at an edge and must end exactly N edges later
    int       m_edge  = 0;
    int       m_start = 0;
    bit       m_run   = 1'b0;
    bit       m_tick  = 1'b0;
    bit [1:0] m_cks   = 2'd0;

    always @(posedge pclk) begin
        m_edge = m_edge + 1;
        if (preset) begin
            m_run = 1'b0; m_tick = 1'b0; m_cks = 2'd0;
        end else if (!m_run) begin
            m_tick = 1'b0;
            if (bus.en) begin
                m_run = 1'b1; m_start = m_edge; m_cks = bus.cks;
            end
        end else if (!bus.en) begin
            m_run = 1'b0; m_tick = 1'b0;
        end else if (bus.load) begin
            m_start = m_edge; m_tick = 1'b0;
        end else if (m_edge - m_start == (2 << m_cks)) begin
            m_tick = 1'b1; m_start = m_edge; m_cks = bus.cks;
        end else begin
            m_tick = 1'b0;
        end
    end

    always @(negedge pclk) begin
        if (check_on) begin
            chk("model_tick", int'(bus.tick), int'(m_tick));
            chk("model_busy", int'(bus.busy), int'(m_run));
            chk("model_cks_active", int'(bus.cks_active), int'(m_cks));
        end
    end

    task automatic cycle();
        @(posedge pclk);
        #2;
        cyc++;
    endtask

    task automatic run_until_tick(input int maxc, output int at);
        at = -1000;
        for (int i = 0; i < maxc; i++) begin
            cycle();
            if (bus.tick) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic run_count(input int n, output int cnt, output int first);
        cnt   = 0;
        first = -1000;
        for (int i = 0; i < n; i++) begin
            cycle();
            if (bus.tick) begin
                if (cnt == 0) first = cyc;
                cnt++;
            end
        end
    endtask

    task automatic restart(input logic [1:0] sel, output int e0);
        bus.en = 1'b0;
        cycle();
        bus.cks = sel;
        bus.en  = 1'b1;
        cycle();
        e0 = cyc;
    endtask

    int e0, at, at2, cnt, first;

    initial begin
        bus.en   = 1'b1;
        bus.cks  = 2'b11;
        bus.load = 1'b0;

        // 1: reset dominates, then first tick N=16 edges after release
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_on = 1'b1;
            chk("reset_tick", int'(bus.tick), 0);
            chk("reset_busy", int'(bus.busy), 0);
            chk("reset_cks_active", int'(bus.cks_active), 0);
        end
        preset = 1'b0;
        cycle();
        e0 = cyc;
        run_until_tick(40, at);
        chk("first_tick_after_reset", at - e0, 16);

        // 2: divide by 2 -> 50 ticks in 100 cycles, first at E0+2
        restart(2'b00, e0);
        run_count(100, cnt, first);
        chk("div2_count", cnt, 50);
        chk("div2_first", first - e0, 2);

        // 3: divide by 16, stop, resume
        restart(2'b11, e0);
        run_count(200, cnt, first);
        chk("div16_count", cnt, 12);
        bus.en = 1'b0;
        run_count(200, cnt, first);
        chk("disabled_count", cnt, 0);
        chk("disabled_busy", int'(bus.busy), 0);
        bus.en = 1'b1;
        cycle();
        e0 = cyc;
        run_until_tick(40, at);
        chk("reenable_first", at - e0, 16);

        // 4: select change mid-period takes effect at next boundary
        restart(2'b00, e0);
        run_until_tick(10, at);
        chk("cks_sw_first", at - e0, 2);
        chk("cks_sw_old_active", int'(bus.cks_active), 0);
        bus.cks = 2'b11;
        run_until_tick(10, at2);
        chk("cks_sw_old_period", at2 - at, 2);
        chk("cks_sw_new_active", int'(bus.cks_active), 3);
        run_until_tick(40, at);
        chk("cks_sw_new_period", at - at2, 16);

        // 5: load at div_cnt=9 restarts phase; load in IDLE ignored
        run_until_tick(40, at);
        for (int i = 0; i < 9; i++) cycle();
        bus.load = 1'b1;
        cycle();
        e0 = cyc;
        bus.load = 1'b0;
        run_until_tick(40, at);
        chk("load_next_tick", at - e0, 16);
        bus.en = 1'b0;
        cycle();
        bus.load = 1'b1;
        cycle();
        chk("idle_load_tick", int'(bus.tick), 0);
        chk("idle_load_busy", int'(bus.busy), 0);
        bus.load = 1'b0;
        bus.en   = 1'b1;
        cycle();
        e0 = cyc;
        run_until_tick(40, at);
        chk("idle_load_first", at - e0, 16);

        // 6: drop enable on the edge a tick is due
        restart(2'b01, e0);
        run_until_tick(10, at);
        chk("div4_first", at - e0, 4);
        for (int i = 0; i < 3; i++) cycle();
        bus.en = 1'b0;
        cycle();
        chk("drop_en_tick", int'(bus.tick), 0);
        chk("drop_en_busy", int'(bus.busy), 0);
        chk("drop_en_div", int'(dut.r_div_cnt), 0);
        cycle();
        chk("drop_en_tick_after", int'(bus.tick), 0);

        // Reset in the middle of a run
        restart(2'b10, e0);
        for (int i = 0; i < 5; i++) cycle();
        preset = 1'b1;
        cycle();
        chk("midrun_reset_busy", int'(bus.busy), 0);
        chk("midrun_reset_cks", int'(bus.cks_active), 0);
        preset = 1'b0;
        cycle();
        e0 = cyc;
        run_until_tick(20, at);
        chk("midrun_reset_first", at - e0, 8);

        cycle();
        check_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
